acq_event_reader_async: RTL and testbench

- Consumer end of the Acquisition Event FIFO in asynchronous mode.
- Pops one acquisition-info word per readout: {5'd0, trig_type[2:0], trig_num[23:0]}.
- Presents a readout request to the command manager and waits for it to finish.
- Then returns a one-cycle readout_done to the channel acquisition controller, which re-arms it.
- Also checks trigger-number continuity and word format. Sits between the FIFO read port and the command manager.

---
 rtl/acq_event_reader_async_if.sv | 23 ++
 rtl/acq_event_reader_async.sv | 103 ++++++++++
 tb/tb_acq_event_reader_async.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_event_reader_async_if.sv
// rtl/acq_event_reader_async_if.sv - FIFO read port and command-manager readout handshake bundle
interface acq_event_reader_async_if;
  logic        fifo_valid;
  logic [31:0] fifo_data;
  logic        fifo_ready;
  logic        readout_req;
  logic [2:0]  readout_trig_type;
  logic [23:0] readout_trig_num;
  logic        readout_ack;
  logic        readout_complete;
  logic        readout_done;

  // master: the event reader; slave: the FIFO / command manager / controller side
  modport master (
    input  fifo_valid, fifo_data, readout_ack, readout_complete,
    output fifo_ready, readout_req, readout_trig_type, readout_trig_num, readout_done
  );

  modport slave (
    output fifo_valid, fifo_data, readout_ack, readout_complete,
    input  fifo_ready, readout_req, readout_trig_type, readout_trig_num, readout_done
  );
endinterface

// File: rtl/acq_event_reader_async.sv
// rtl/acq_event_reader_async.sv - acquisition event FIFO consumer driving one readout per popped word
// Optional readout watchdog enabled by ACQ_READOUT_TIMEOUT_EN.
module acq_event_reader_async #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd40_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  acq_event_reader_async_if.master     bus,
  output logic                         seq_err,
  output logic                         fmt_err,
  output logic                         timeout_err,
  output logic [31:0]                  readout_count,
  output logic [4:0]                   state
);

  typedef enum logic [4:0] {
    IDLE          = 5'b00001,
    REQUEST       = 5'b00010,
    WAIT_COMPLETE = 5'b00100,
    DONE          = 5'b01000,
    DRAIN         = 5'b10000
  } state_t;

  state_t      state_q, state_d;
  logic        pop;
  logic        fmt_bad;
  logic        expire;
  logic [23:0] expected_num;
  logic        first_seen;

  assign state          = state_q;
  assign bus.fifo_ready = state_q[0];
  assign pop            = bus.fifo_valid & state_q[0];
  assign fmt_bad        = |bus.fifo_data[31:27];

`ifdef ACQ_READOUT_TIMEOUT_EN
  logic [31:0] wdog;

  assign expire = (state_q == WAIT_COMPLETE) && !bus.readout_complete &&
                  (wdog == TIMEOUT_CYCLES - 32'd1);

  // Counter is zero on the first WAIT_COMPLETE cycle since it idles at zero elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog        <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      wdog <= (state_q == WAIT_COMPLETE) ? wdog + 32'd1 : 32'd0;
      if (expire) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign expire                = 1'b0;
  assign timeout_err           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (pop && !fmt_bad) state_d = REQUEST;
      REQUEST:       if (bus.readout_ack) state_d = bus.readout_complete ? DONE : WAIT_COMPLETE;
      WAIT_COMPLETE: if (bus.readout_complete || expire) state_d = DONE;
      DONE:          state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  // req/done are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= IDLE;
      bus.readout_req       <= 1'b0;
      bus.readout_done      <= 1'b0;
      bus.readout_trig_type <= 3'd0;
      bus.readout_trig_num  <= 24'd0;
      seq_err               <= 1'b0;
      fmt_err               <= 1'b0;
      readout_count         <= 32'd0;
      expected_num          <= 24'd0;
      first_seen            <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus.readout_req  <= (state_d == REQUEST);
      bus.readout_done <= (state_d == DONE);
      if (state_d == DONE) readout_count <= readout_count + 32'd1;
      if (pop) begin
        if (fmt_bad) begin
          fmt_err <= 1'b1;
        end else begin
          bus.readout_trig_type <= bus.fifo_data[26:24];
          bus.readout_trig_num  <= bus.fifo_data[23:0];
          if (first_seen && (bus.fifo_data[23:0] != expected_num)) seq_err <= 1'b1;
          expected_num <= bus.fifo_data[23:0] + 24'd1;
          first_seen   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acq_event_reader_async.sv
// tb/tb_acq_event_reader_async.sv - scoreboard bench for acq_event_reader_async
module tb_acq_event_reader_async;

  typedef struct packed {
    logic [2:0]  t;
    logic [23:0] n;
  } exp_t;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_REQ  = 5'b00010;
  localparam logic [4:0] S_WAIT = 5'b00100;
  localparam logic [4:0] S_DONE = 5'b01000;

  logic        clk = 1'b0;
  logic        reset;
  logic        seq_err, fmt_err, timeout_err;
  logic [31:0] readout_count;
  logic [4:0]  state;

  int          checks = 0;
  int          errors = 0;
  int          count_model = 0;
  exp_t        req_q[$];
  logic [31:0] done_q[$];
  logic        prev_req = 1'b0;
  logic        prev_done = 1'b0;
  exp_t        e;
  int          n;

  acq_event_reader_async_if bus();

  acq_event_reader_async #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .seq_err      (seq_err),
    .fmt_err      (fmt_err),
    .timeout_err  (timeout_err),
    .readout_count(readout_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    count_model = 0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.fifo_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (k >= 50) chk("fifo_ready_timeout", 32'(bus.fifo_ready), 32'd1);
  endtask

  task automatic pop_word(input logic [31:0] w);
    wait_ready();
    bus.fifo_valid = 1'b1;
    bus.fifo_data  = w;
    @(negedge clk);
    bus.fifo_valid = 1'b0;
  endtask

  task automatic readout(input logic [31:0] w, input bit together);
    req_q.push_back('{w[26:24], w[23:0]});
    count_model++;
    done_q.push_back(32'(count_model));
    pop_word(w);
    chk("ready_low_after_pop", 32'(bus.fifo_ready), 32'd0);
    chk("state_request", 32'(state), 32'(S_REQ));
    chk("req_high", 32'(bus.readout_req), 32'd1);
    bus.readout_ack      = 1'b1;
    bus.readout_complete = together;
    @(negedge clk);
    bus.readout_ack      = 1'b0;
    bus.readout_complete = 1'b0;
    if (!together) begin
      chk("state_wait", 32'(state), 32'(S_WAIT));
      chk("req_dropped", 32'(bus.readout_req), 32'd0);
      repeat (3) @(negedge clk);
      bus.readout_complete = 1'b1;
      @(negedge clk);
      bus.readout_complete = 1'b0;
    end
    chk("state_done", 32'(state), 32'(S_DONE));
    chk("done_pulse", 32'(bus.readout_done), 32'd1);
    @(negedge clk);
    chk("done_cleared", 32'(bus.readout_done), 32'd0);
    chk("ready_back", 32'(bus.fifo_ready), 32'd1);
  endtask

  // Monitor: compares each new request and each done pulse against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req  = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (bus.readout_req && !prev_req) begin
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got req=1 expected none");
          end else begin
            e = req_q.pop_front();
            chk("trig_type", 32'(bus.readout_trig_type), 32'(e.t));
            chk("trig_num", 32'(bus.readout_trig_num), 32'(e.n));
          end
        end
        if (bus.readout_done) begin
          if (prev_done) begin
            checks++;
            errors++;
            $display("FAIL done_width: got done high 2 cycles expected 1");
          end else if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected none");
          end else begin
            chk("readout_count", readout_count, done_q.pop_front());
          end
        end
        prev_req  = bus.readout_req;
        prev_done = bus.readout_done;
      end
    end
  end

  initial begin
    bus.fifo_valid       = 1'b0;
    bus.fifo_data        = 32'd0;
    bus.readout_ack      = 1'b0;
    bus.readout_complete = 1'b0;
    reset                = 1'b1;
    @(negedge clk);
    do_reset();

    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_ready", 32'(bus.fifo_ready), 32'd1);
    chk("rst_req", 32'(bus.readout_req), 32'd0);
    chk("rst_done", 32'(bus.readout_done), 32'd0);
    chk("rst_seq", 32'(seq_err), 32'd0);
    chk("rst_fmt", 32'(fmt_err), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_count", readout_count, 32'd0);
    chk("rst_num", 32'(bus.readout_trig_num), 32'd0);

    readout(32'h0300_0005, 1'b0);
    chk("seq_first", 32'(seq_err), 32'd0);
    readout(32'h0000_0006, 1'b0);
    chk("seq_6", 32'(seq_err), 32'd0);
    readout(32'h0000_0008, 1'b0);
    chk("seq_gap", 32'(seq_err), 32'd1);
    readout(32'h0000_0009, 1'b0);
    chk("seq_sticky", 32'(seq_err), 32'd1);

    do_reset();
    chk("seq_cleared", 32'(seq_err), 32'd0);
    readout(32'h00FF_FFFF, 1'b0);
    readout(32'h0000_0000, 1'b0);
    chk("seq_wrap", 32'(seq_err), 32'd0);
    readout(32'h0200_0001, 1'b1);
    chk("seq_together", 32'(seq_err), 32'd0);
    chk("count_3", readout_count, 32'd3);

    pop_word(32'h0800_0001);
    chk("fmt_set", 32'(fmt_err), 32'd1);
    chk("fmt_state", 32'(state), 32'(S_IDLE));
    chk("fmt_ready", 32'(bus.fifo_ready), 32'd1);
    chk("fmt_no_req", 32'(bus.readout_req), 32'd0);
    readout(32'h0700_0002, 1'b0);
    chk("fmt_then_seq", 32'(seq_err), 32'd0);
    chk("fmt_sticky", 32'(fmt_err), 32'd1);

    req_q.push_back('{3'd1, 24'd3});
    pop_word(32'h0100_0003);
    bus.readout_ack = 1'b1;
    @(negedge clk);
    bus.readout_ack = 1'b0;
    chk("pre_reset_wait", 32'(state), 32'(S_WAIT));
    repeat (2) @(negedge clk);
    do_reset();
    chk("midrst_state", 32'(state), 32'(S_IDLE));
    chk("midrst_done", 32'(bus.readout_done), 32'd0);
    chk("midrst_count", readout_count, 32'd0);
    chk("midrst_fmt", 32'(fmt_err), 32'd0);
    repeat (5) @(negedge clk);

    req_q.push_back('{3'd0, 24'd4});
`ifdef ACQ_READOUT_TIMEOUT_EN
    count_model++;
    done_q.push_back(32'(count_model));
`endif
    pop_word(32'h0000_0004);
    bus.readout_ack = 1'b1;
    @(negedge clk);
    bus.readout_ack = 1'b0;
    n = 0;
`ifdef ACQ_READOUT_TIMEOUT_EN
    while (state == S_WAIT && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("wdog_cycles", 32'(n), 32'd16);
    chk("wdog_done", 32'(bus.readout_done), 32'd1);
    chk("wdog_err", 32'(timeout_err), 32'd1);
    @(negedge clk);
    chk("wdog_ready", 32'(bus.fifo_ready), 32'd1);
`else
    while (state == S_WAIT && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("hold_cycles", 32'(n), 32'd1000);
    chk("hold_state", 32'(state), 32'(S_WAIT));
    chk("hold_tmo", 32'(timeout_err), 32'd0);
    do_reset();
`endif

    repeat (3) @(negedge clk);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
